nios2_system_onchip_memory_pipelined: RTL and testbench

Parametrised single-port on-chip RAM exposed as an Avalon-MM slave on the Nios II system interconnect, succeeding the fixed 32-bit x 8192-word instance. It adds configurable data width, depth and read latency, a pipelined `readdatavalid` read path, a `waitrequest` backpressure output, and a post-reset clear sequencer that zero-fills the array. An optional per-byte parity store with error detection can be compiled in.

---
 rtl/nios2_system_onchip_memory_pipelined.sv | 220 ++++++++++++++++++++++
 tb/tb_nios2_system_onchip_memory_pipelined.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_system_onchip_memory_pipelined.sv
// Parametrised single-port Avalon-MM on-chip RAM with pipelined readdatavalid, clken stall and post-reset clear.
// Optional per-byte even-parity store and sticky error flag: define ONCHIP_MEM_PARITY_EN.
module nios2_system_onchip_memory_pipelined #(
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 8192,
   parameter int ADDR_W         = 13,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  chipselect,
   input  logic [ADDR_W-1:0]     address,
   input  logic                  read,
   input  logic                  write,
   input  logic [DATA_W/8-1:0]   byteenable,
   input  logic [DATA_W-1:0]     writedata,
   input  logic                  clken,
   output logic [DATA_W-1:0]     readdata,
   output logic                  readdatavalid,
   output logic                  waitrequest,
   output logic                  init_done,
   output logic                  parity_error
);

   localparam int NB = DATA_W / 8;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_q, clr_d;
   logic                init_done_q, init_done_d;

   logic                accept_s;
   logic                rd_accept_s;
   logic                wr_accept_s;

   logic                mem_we_s;
   logic [ADDR_W-1:0]   mem_addr_s;
   logic [NB-1:0]       mem_be_s;
   logic [DATA_W-1:0]   mem_wdata_s;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   rd_word_s;

   logic                s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0]   s1_data_q, s1_data_d;
   logic                out_valid_s;
   logic [DATA_W-1:0]   out_data_s;
   logic                rdv_q, rdv_d;
   logic [DATA_W-1:0]   readdata_q, readdata_d;

   // Bus is held off until one edge after the clear finishes, so init_done and waitrequest change together.
   assign waitrequest = ~init_done_q | ~clken;
   assign accept_s    = chipselect & (read | write) & ~waitrequest;
   assign wr_accept_s = accept_s & write;
   assign rd_accept_s = accept_s & read & ~write;
   assign rd_word_s   = mem[address];

   always_comb begin
      state_d     = state_q;
      clr_d       = clr_q;
      init_done_d = (state_q == ST_READY);
      mem_we_s    = 1'b0;
      mem_addr_s  = address;
      mem_be_s    = byteenable;
      mem_wdata_s = writedata;
      case (state_q)
         ST_INIT: begin
            if (CLEAR_ON_RESET != 0) begin
               mem_we_s    = 1'b1;
               mem_addr_s  = clr_q;
               mem_be_s    = {NB{1'b1}};
               mem_wdata_s = {DATA_W{1'b0}};
               clr_d       = clr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               if (clr_q == LAST_ADDR) begin
                  state_d = ST_READY;
               end else begin
                  state_d = ST_INIT;
               end
            end else begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            mem_we_s = wr_accept_s;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_INIT;
         clr_q       <= {ADDR_W{1'b0}};
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_q       <= clr_d;
         init_done_q <= init_done_d;
      end
   end

   // Storage array has no reset; its contents are defined by the clear sequence or by writes.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (mem_we_s && mem_be_s[b]) begin
            mem[mem_addr_s][b*8 +: 8] <= mem_wdata_s[b*8 +: 8];
         end
      end
   end

   // Stage 1 only matters for READ_LATENCY=2; stalled stages hold, the output strobe never repeats.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      if (clken) begin
         s1_valid_d = rd_accept_s;
         s1_data_d  = rd_word_s;
      end else begin
         s1_valid_d = s1_valid_q;
         s1_data_d  = s1_data_q;
      end
      if (READ_LATENCY == 2) begin
         out_valid_s = clken & s1_valid_q;
         out_data_s  = s1_data_q;
      end else begin
         out_valid_s = rd_accept_s;
         out_data_s  = rd_word_s;
      end
      rdv_d = out_valid_s;
      if (out_valid_s) begin
         readdata_d = out_data_s;
      end else begin
         readdata_d = readdata_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= {DATA_W{1'b0}};
         rdv_q      <= 1'b0;
         readdata_q <= {DATA_W{1'b0}};
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         rdv_q      <= rdv_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata      = readdata_q;
   assign readdatavalid = rdv_q;
   assign init_done     = init_done_q;

`ifdef ONCHIP_MEM_PARITY_EN
   function automatic logic [NB-1:0] byte_parity(input logic [DATA_W-1:0] d);
      logic [NB-1:0] p;
      p = {NB{1'b0}};
      for (int b = 0; b < NB; b++) begin
         p[b] = ^d[b*8 +: 8];
      end
      return p;
   endfunction

   logic [NB-1:0]       par_mem [DEPTH];
   logic [NB-1:0]       wpar_s;
   logic [NB-1:0]       rd_par_s;
   logic [NB-1:0]       par1_q, par1_d;
   logic [NB-1:0]       out_par_s;
   logic                perr_q, perr_d;

   assign wpar_s   = byte_parity(mem_wdata_s);
   assign rd_par_s = par_mem[address];

   // Parity bits follow every byte write, including the zero fill.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (mem_we_s && mem_be_s[b]) begin
            par_mem[mem_addr_s][b] <= wpar_s[b];
         end
      end
   end

   always_comb begin
      if (clken) begin
         par1_d = rd_par_s;
      end else begin
         par1_d = par1_q;
      end
      if (READ_LATENCY == 2) begin
         out_par_s = par1_q;
      end else begin
         out_par_s = rd_par_s;
      end
      perr_d = perr_q | (out_valid_s & (byte_parity(out_data_s) != out_par_s));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         par1_q <= {NB{1'b0}};
         perr_q <= 1'b0;
      end else begin
         par1_q <= par1_d;
         perr_q <= perr_d;
      end
   end

   assign parity_error = perr_q;
`else
   assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_nios2_system_onchip_memory_pipelined.sv
// Randomised self-checking bench: two instances (READ_LATENCY 2 and 1) against a queue-based reference model.
module tb_nios2_system_onchip_memory_pipelined;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        chipselect = 1'b0;
   logic [3:0]  address = 4'd0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [3:0]  byteenable = 4'd0;
   logic [31:0] writedata = 32'd0;
   logic        clken = 1'b1;

   logic [31:0] rd_o [2];
   logic        rdv_o [2];
   logic        wr_o [2];
   logic        done_o [2];
   logic        perr_o [2];

   always #5 clk = ~clk;

   nios2_system_onchip_memory_pipelined #(
      .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
   ) u_dut2 (
      .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
      .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
      .clken(clken), .readdata(rd_o[0]), .readdatavalid(rdv_o[0]),
      .waitrequest(wr_o[0]), .init_done(done_o[0]), .parity_error(perr_o[0])
   );

   nios2_system_onchip_memory_pipelined #(
      .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
   ) u_dut1 (
      .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
      .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
      .clken(clken), .readdata(rd_o[1]), .readdatavalid(rdv_o[1]),
      .waitrequest(wr_o[1]), .init_done(done_o[1]), .parity_error(perr_o[1])
   );

   typedef struct {
      logic [31:0] data;
      int          rem;
      int          addr;
   } rd_t;

   int          n_checks = 0;
   int          n_errors = 0;
   int          lat [2] = '{2, 1};
   logic [31:0] model_mem [DEPTH];
   logic        corrupt [DEPTH];
   rd_t         pq [2][$];
   logic        exp_v [2];
   logic [31:0] exp_d [2];
   logic        exp_perr [2];
   int          edges = 0;
   logic        ready = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i] = 32'd0;
         corrupt[i]   = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
         pq[k].delete();
         exp_v[k]    = 1'b0;
         exp_d[k]    = 32'd0;
         exp_perr[k] = 1'b0;
      end
      edges = 0;
      ready = 1'b0;
   endtask

   // Reference behaviour at one rising edge, from the pre-edge inputs.
   task automatic model_edge();
      logic acc;
      rd_t  item;
      acc = ready && chipselect && (read || write) && clken;
      for (int k = 0; k < 2; k++) begin
         exp_v[k] = 1'b0;
         if (clken) begin
            for (int i = 0; i < pq[k].size(); i++) pq[k][i].rem = pq[k][i].rem - 1;
            if (acc && read && !write) begin
               item.data = model_mem[address];
               item.rem  = lat[k] - 1;
               item.addr = int'(address);
               pq[k].push_back(item);
            end
            if (pq[k].size() > 0 && pq[k][0].rem == 0) begin
               item     = pq[k].pop_front();
               exp_v[k] = 1'b1;
               exp_d[k] = item.data;
               if (corrupt[item.addr]) exp_perr[k] = 1'b1;
            end
         end
      end
      if (acc && write) begin
         for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) model_mem[address][b*8 +: 8] = writedata[b*8 +: 8];
         end
         if (byteenable[0]) corrupt[address] = 1'b0;
      end
      edges++;
      if (edges >= DEPTH + 1) ready = 1'b1;
   endtask

   task automatic compare();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("L%0d waitrequest", lat[k]), {31'd0, wr_o[k]}, {31'd0, ~ready | ~clken});
         chk($sformatf("L%0d init_done", lat[k]), {31'd0, done_o[k]}, {31'd0, ready});
         chk($sformatf("L%0d readdatavalid", lat[k]), {31'd0, rdv_o[k]}, {31'd0, exp_v[k]});
         chk($sformatf("L%0d readdata", lat[k]), rd_o[k], exp_d[k]);
         chk($sformatf("L%0d parity_error", lat[k]), {31'd0, perr_o[k]}, {31'd0, exp_perr[k]});
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
      @(negedge clk);
   endtask

   task automatic cmd(input logic c, input logic r, input logic w, input logic [3:0] a,
                      input logic [3:0] be, input logic [31:0] d);
      chipselect = c; read = r; write = w; address = a; byteenable = be; writedata = d;
      step();
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("reset readdata", rd_o[k], 32'd0);
         chk("reset readdatavalid", {31'd0, rdv_o[k]}, 32'd0);
         chk("reset waitrequest", {31'd0, wr_o[k]}, 32'd1);
         chk("reset init_done", {31'd0, done_o[k]}, 32'd0);
         chk("reset parity_error", {31'd0, perr_o[k]}, 32'd0);
      end
      model_reset();
      chipselect = 1'b0; read = 1'b0; write = 1'b0; clken = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic run_init();
      int cnt;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (wr_o[0]) cnt++;
         if (done_o[0]) break;
      end
      chk("init waitrequest cycles", cnt, 32'd16);
      chk("init_done after clear", {31'd0, done_o[0]}, 32'd1);
   endtask

   initial begin
      int n;
      #2;
      do_reset();
      run_init();

      // Whole array reads back as zero after the clear.
      for (int a = 0; a < DEPTH; a++) cmd(1'b1, 1'b1, 1'b0, 4'(a), 4'hF, 32'd0);
      idle(3);

      cmd(1'b1, 1'b0, 1'b1, 4'd5, 4'hF, 32'hDEADBEEF);
      cmd(1'b1, 1'b0, 1'b1, 4'd5, 4'h1, 32'h000000AA);
      cmd(1'b1, 1'b1, 1'b0, 4'd5, 4'hF, 32'd0);
      idle(3);
      chk("byteenable merge L2", rd_o[0], 32'hDEADBEAA);
      chk("byteenable merge L1", rd_o[1], 32'hDEADBEAA);

      cmd(1'b1, 1'b0, 1'b1, 4'd1, 4'hF, 32'h11);
      cmd(1'b1, 1'b0, 1'b1, 4'd2, 4'hF, 32'h22);
      cmd(1'b1, 1'b0, 1'b1, 4'd3, 4'hF, 32'h33);
      for (int a = 1; a <= 3; a++) cmd(1'b1, 1'b1, 1'b0, 4'(a), 4'hF, 32'd0);
      idle(3);
      chk("back-to-back last data", rd_o[0], 32'h33);

      // Stall for three cycles right after a read is accepted.
      cmd(1'b1, 1'b1, 1'b0, 4'd2, 4'hF, 32'd0);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         clken = (i >= 3);
         step();
         n++;
         if (rdv_o[0]) break;
      end
      clken = 1'b1;
      chk("stall latency L2", n, 32'd4);
      chk("stall data L2", rd_o[0], 32'h22);
      idle(2);

      cmd(1'b1, 1'b1, 1'b1, 4'd7, 4'hF, 32'h55);
      idle(2);
      cmd(1'b1, 1'b1, 1'b0, 4'd7, 4'hF, 32'd0);
      idle(3);
      chk("read+write addr 7", rd_o[1], 32'h55);

      for (int i = 0; i < 400; i++) begin
         chipselect = ($urandom_range(0, 7) != 0);
         read       = $urandom_range(0, 1) == 1;
         write      = $urandom_range(0, 2) == 0;
         address    = 4'($urandom_range(0, DEPTH - 1));
         byteenable = 4'($urandom_range(0, 15));
         writedata  = $urandom;
         clken      = ($urandom_range(0, 5) != 0);
         step();
      end
      chipselect = 1'b0; read = 1'b0; write = 1'b0; clken = 1'b1;
      idle(4);

`ifdef ONCHIP_MEM_PARITY_EN
      cmd(1'b1, 1'b0, 1'b1, 4'd9, 4'hF, 32'h12345678);
      u_dut2.par_mem[9][0] = ~u_dut2.par_mem[9][0];
      u_dut1.par_mem[9][0] = ~u_dut1.par_mem[9][0];
      corrupt[9] = 1'b1;
      cmd(1'b1, 1'b1, 1'b0, 4'd9, 4'hF, 32'd0);
      idle(6);
      chk("parity sticky L2", {31'd0, perr_o[0]}, 32'd1);
      chk("parity sticky L1", {31'd0, perr_o[1]}, 32'd1);
`endif

      // Reset with a read still in flight, then re-clear.
      cmd(1'b1, 1'b1, 1'b0, 4'd3, 4'hF, 32'd0);
      do_reset();
      run_init();
      for (int a = 0; a < DEPTH; a++) cmd(1'b1, 1'b1, 1'b0, 4'(a), 4'hF, 32'd0);
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
